// File: rtl/slc3_core_param.sv
// Multi-cycle SLC-3 core with parametrised word width, register count and reset PC.
// Memory accesses use a request/ready handshake held from state entry until ready.
//
// state | meaning
// HALT  | idle after reset, waits for run_i
// F1    | MAR <= PC, PC <= PC+1
// F2    | instruction read, wait for mem_ready
// F3    | IR <= MDR
// DEC   | opcode dispatch, BEN latch, PAUSE LED load
// ALU   | ADD/AND/NOT writeback and NZP
// BR    | conditional PC-relative branch
// JMP   | PC <= BaseR
// JSR   | R7 <= PC, PC <= PC+off11 or BaseR
// LDR1  | MAR <= BaseR+off6
// LDR2  | data read, wait for mem_ready
// LDR3  | DR <= MDR, set NZP
// STR1  | MAR <= BaseR+off6
// STR2  | MDR <= SR
// STR3  | data write, wait for mem_ready
// P1    | PAUSE, wait continue_i=1
// P2    | PAUSE, wait continue_i=0
module slc3_core_param #(
    parameter int                DATA_W   = 16,
    parameter int                NUM_REGS = 8,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_i,
    input  logic              continue_i,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_mem_ena,
    output logic              mem_wr_ena,
    output logic [15:0]       led_o,
    output logic [15:0]       hex_display_debug,
    output logic              halted_o
);

    localparam int REG_AW = (NUM_REGS > 8) ? $clog2(NUM_REGS) : 3;

    typedef enum logic [4:0] {
        S_HALT = 5'd0,
        S_F1   = 5'd1,
        S_F2   = 5'd2,
        S_F3   = 5'd3,
        S_DEC  = 5'd4,
        S_ALU  = 5'd5,
        S_BR   = 5'd6,
        S_JMP  = 5'd7,
        S_JSR  = 5'd8,
        S_LDR1 = 5'd9,
        S_LDR2 = 5'd10,
        S_LDR3 = 5'd11,
        S_STR1 = 5'd12,
        S_STR2 = 5'd13,
        S_STR3 = 5'd14,
        S_P1   = 5'd16,
        S_P2   = 5'd17
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       led_q, led_d;
    logic [2:0]        nzp_q, nzp_d;
    logic              ben_q, ben_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic              rf_we;
    logic [REG_AW-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;

    logic [DATA_W-1:0] sr1, sr2, sr_st, alu_b, alu_res, base_off6;

    function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
        return {{(DATA_W-5){v[4]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext6(input logic [5:0] v);
        return {{(DATA_W-6){v[5]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext9(input logic [8:0] v);
        return {{(DATA_W-9){v[8]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext11(input logic [10:0] v);
        return {{(DATA_W-11){v[10]}}, v};
    endfunction

    function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] r);
        if (r == '0)            return 3'b010;
        else if (r[DATA_W-1])   return 3'b100;
        else                    return 3'b001;
    endfunction

    assign sr1       = regs_q[REG_AW'(ir_q[8:6])];
    assign sr2       = regs_q[REG_AW'(ir_q[2:0])];
    assign sr_st     = regs_q[REG_AW'(ir_q[11:9])];
    assign alu_b     = ir_q[5] ? sext5(ir_q[4:0]) : sr2;
    assign base_off6 = sr1 + sext6(ir_q[5:0]);

    always_comb begin
        case (ir_q[15:12])
            4'b0001: alu_res = sr1 + alu_b;
            4'b0101: alu_res = sr1 & alu_b;
            default: alu_res = ~sr1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        ir_d    = ir_q;
        led_d   = led_q;
        nzp_d   = nzp_q;
        ben_d   = ben_q;
        rf_we   = 1'b0;
        rf_wa   = REG_AW'(ir_q[11:9]);
        rf_wd   = '0;

        case (state_q)
            S_HALT: if (run_i) state_d = S_F1;
            S_F1: begin
                mar_d   = pc_q;
                pc_d    = pc_q + DATA_W'(1);
                state_d = S_F2;
            end
            S_F2: begin
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_F3;
                end
            end
            S_F3: begin
                ir_d    = mdr_q[15:0];
                state_d = S_DEC;
            end
            S_DEC: begin
                ben_d = |(ir_q[11:9] & nzp_q);
                case (ir_q[15:12])
                    4'b0001, 4'b0101, 4'b1001: state_d = S_ALU;
                    4'b0000:                   state_d = S_BR;
                    4'b1100:                   state_d = S_JMP;
                    4'b0100:                   state_d = S_JSR;
                    4'b0110:                   state_d = S_LDR1;
                    4'b0111:                   state_d = S_STR1;
                    4'b1101: begin
                        led_d   = {4'h0, ir_q[11:0]};
                        state_d = S_P1;
                    end
                    default:                   state_d = S_F1;
                endcase
            end
            S_ALU: begin
                rf_we   = 1'b1;
                rf_wd   = alu_res;
                nzp_d   = nzp_of(alu_res);
                state_d = S_F1;
            end
            S_BR: begin
                if (ben_q) pc_d = pc_q + sext9(ir_q[8:0]);
                state_d = S_F1;
            end
            S_JMP: begin
                pc_d    = sr1;
                state_d = S_F1;
            end
            S_JSR: begin
                // sr1 is the pre-write BaseR, so JSRR R7 jumps to the old link value
                rf_we   = 1'b1;
                rf_wa   = REG_AW'(3'd7);
                rf_wd   = pc_q;
                pc_d    = ir_q[11] ? (pc_q + sext11(ir_q[10:0])) : sr1;
                state_d = S_F1;
            end
            S_LDR1: begin
                mar_d   = base_off6;
                state_d = S_LDR2;
            end
            S_LDR2: begin
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_LDR3;
                end
            end
            S_LDR3: begin
                rf_we   = 1'b1;
                rf_wd   = mdr_q;
                nzp_d   = nzp_of(mdr_q);
                state_d = S_F1;
            end
            S_STR1: begin
                mar_d   = base_off6;
                state_d = S_STR2;
            end
            S_STR2: begin
                mdr_d   = sr_st;
                state_d = S_STR3;
            end
            S_STR3: if (mem_ready) state_d = S_F1;
            S_P1:   if (continue_i) state_d = S_P2;
            S_P2:   if (!continue_i) state_d = S_F1;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HALT;
            pc_q    <= RESET_PC;
            mar_q   <= '0;
            mdr_q   <= '0;
            ir_q    <= '0;
            led_q   <= '0;
            nzp_q   <= 3'b010;
            ben_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            ir_q    <= ir_d;
            led_q   <= led_d;
            nzp_q   <= nzp_d;
            ben_q   <= ben_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (rf_we) begin
            regs_q[rf_wa] <= rf_wd;
        end
    end

    // Request is a pure function of state, so it drops the cycle after completion or reset.
    assign mem_mem_ena       = (state_q == S_F2) || (state_q == S_LDR2) || (state_q == S_STR3);
    assign mem_wr_ena        = (state_q == S_STR3);
    assign mem_addr          = mar_q;
    assign mem_wdata         = mdr_q;
    assign led_o             = led_q;
    assign hex_display_debug = ir_q;
    assign halted_o          = (state_q == S_HALT);

endmodule
